put_fsm: RTL and testbench

//  Write-side sub-FSM of the cache controller, the counterpart of the GET sub-FSM.

---
 rtl/put_fsm.sv | 158 +++++++++++++++
 tb/tb_put_fsm.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/put_fsm.sv
// -----------------------------------------------------------------------------
// put_fsm
//
// Write-side sub-FSM of the cache controller (counterpart of the GET sub-FSM).
// Executes one PUT command:
//   START  : latch key/value from the command inputs
//   LOOKUP : ask the memory array whether the key is already stored
//   ALLOC  : on a miss, pick the lowest free slot (or fail if the cache is full)
//   WRITE  : issue exactly one write strobe to the chosen slot
//   DONE / ERR : one-cycle completion / failure report to the top controller
// The top controller steps the FSM with en and can restart it with enter.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   en                  step enable; 0 freezes state, latches and timeout count
//   enter               restart: back to START, latches and counter cleared
//   key_i, value_i      PUT command operands, sampled in START
//   lookup_req_o        key lookup request (held until ack)
//   lookup_key_o        latched key presented to the lookup
//   lookup_ack_i        single-cycle lookup result valid
//   lookup_hit_i        key found; qualified by lookup_ack_i
//   lookup_idx_i        slot of the matching key; qualified by ack & hit
//   free_valid_i        at least one free slot exists
//   free_idx_i          lowest free slot index
//   wr_en_o             write strobe to the memory array
//   wr_idx_o            target slot
//   wr_key_o, wr_val_o  latched key / value to be written
//   busy_o              FSM is away from START
//   done_o              PUT completed (1-cycle pulse)
//   error_o             PUT failed: cache full or lookup timeout (1-cycle pulse)
// -----------------------------------------------------------------------------
module put_fsm #(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_W       = 32,
    parameter int VAL_W       = 64,
    parameter int IDX_W       = $clog2(NUM_ENTRIES),
    parameter int TIMEOUT_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             enter,
    input  logic [KEY_W-1:0] key_i,
    input  logic [VAL_W-1:0] value_i,
    output logic             lookup_req_o,
    output logic [KEY_W-1:0] lookup_key_o,
    input  logic             lookup_ack_i,
    input  logic             lookup_hit_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    input  logic             free_valid_i,
    input  logic [IDX_W-1:0] free_idx_i,
    output logic             wr_en_o,
    output logic [IDX_W-1:0] wr_idx_o,
    output logic [KEY_W-1:0] wr_key_o,
    output logic [VAL_W-1:0] wr_val_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);

    localparam logic [2:0] PUT_ST_START  = 3'd0;
    localparam logic [2:0] PUT_ST_LOOKUP = 3'd1;
    localparam logic [2:0] PUT_ST_ALLOC  = 3'd2;
    localparam logic [2:0] PUT_ST_WRITE  = 3'd3;
    localparam logic [2:0] PUT_ST_DONE   = 3'd4;
    localparam logic [2:0] PUT_ST_ERR    = 3'd5;

    // Sized so that TIMEOUT_CYC-1 always fits, including TIMEOUT_CYC == 1.
    localparam int              CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [2:0]       state_q,  state_nxt;
    logic [KEY_W-1:0] key_q,    key_nxt;
    logic [VAL_W-1:0] val_q,    val_nxt;
    logic [IDX_W-1:0] idx_q,    idx_nxt;
    logic [CNT_W-1:0] cnt_q,    cnt_nxt;

    // Next-state and latch update; nothing moves unless en is high.
    always_comb begin
        state_nxt = state_q;
        key_nxt   = key_q;
        val_nxt   = val_q;
        idx_nxt   = idx_q;
        cnt_nxt   = cnt_q;
        if (en) begin
            case (state_q)
                PUT_ST_START: begin
                    key_nxt   = key_i;
                    val_nxt   = value_i;
                    cnt_nxt   = '0;             // fresh timeout window for LOOKUP
                    state_nxt = PUT_ST_LOOKUP;
                end
                PUT_ST_LOOKUP: begin
                    // An ack on the last allowed cycle takes precedence over timeout.
                    if (lookup_ack_i) begin
                        if (lookup_hit_i) begin
                            idx_nxt   = lookup_idx_i;
                            state_nxt = PUT_ST_WRITE;
                        end else begin
                            state_nxt = PUT_ST_ALLOC;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_nxt = PUT_ST_ERR;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end
                PUT_ST_ALLOC: begin
                    if (free_valid_i) begin
                        idx_nxt   = free_idx_i;
                        state_nxt = PUT_ST_WRITE;
                    end else begin
                        state_nxt = PUT_ST_ERR;
                    end
                end
                PUT_ST_WRITE: state_nxt = PUT_ST_DONE;
                PUT_ST_DONE:  state_nxt = PUT_ST_START;
                PUT_ST_ERR:   state_nxt = PUT_ST_START;
                default:      state_nxt = PUT_ST_START;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PUT_ST_START;
            key_q   <= '0;
            val_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else if (enter) begin
            state_q <= PUT_ST_START;
            key_q   <= '0;
            val_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            key_q   <= key_nxt;
            val_q   <= val_nxt;
            idx_q   <= idx_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // The strobe only fires on the cycle WRITE actually advances, so a stall
    // never repeats it; a concurrent restart or reset suppresses it.
    assign wr_en_o      = (state_q == PUT_ST_WRITE) & en & ~enter & ~rst;
    assign lookup_req_o = (state_q == PUT_ST_LOOKUP);
    assign done_o       = (state_q == PUT_ST_DONE) & en;
    assign error_o      = (state_q == PUT_ST_ERR)  & en;
    assign busy_o       = (state_q != PUT_ST_START);
    assign lookup_key_o = key_q;
    assign wr_key_o     = key_q;
    assign wr_val_o     = val_q;
    assign wr_idx_o     = idx_q;

endmodule

// File: tb/tb_put_fsm.sv
module tb_put_fsm;

    localparam int NE = 16;
    localparam int KW = 32;
    localparam int VW = 64;
    localparam int IW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst, en, enter;
    logic [KW-1:0] key_i;
    logic [VW-1:0] value_i;
    logic          lookup_req_o;
    logic [KW-1:0] lookup_key_o;
    logic          lookup_ack_i, lookup_hit_i;
    logic [IW-1:0] lookup_idx_i;
    logic          free_valid_i;
    logic [IW-1:0] free_idx_i;
    logic          wr_en_o;
    logic [IW-1:0] wr_idx_o;
    logic [KW-1:0] wr_key_o;
    logic [VW-1:0] wr_val_o;
    logic          busy_o, done_o, error_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    put_fsm #(
        .NUM_ENTRIES(NE), .KEY_W(KW), .VAL_W(VW), .IDX_W(IW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .enter(enter),
        .key_i(key_i), .value_i(value_i),
        .lookup_req_o(lookup_req_o), .lookup_key_o(lookup_key_o),
        .lookup_ack_i(lookup_ack_i), .lookup_hit_i(lookup_hit_i),
        .lookup_idx_i(lookup_idx_i),
        .free_valid_i(free_valid_i), .free_idx_i(free_idx_i),
        .wr_en_o(wr_en_o), .wr_idx_o(wr_idx_o), .wr_key_o(wr_key_o),
        .wr_val_o(wr_val_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs set afterwards apply to
    // the following edge, and outputs are read after a further #1 settle.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, busy_o, 0);
        chk({tag, ".req"},  lookup_req_o, 0);
        chk({tag, ".wr"},   wr_en_o, 0);
        chk({tag, ".done"}, done_o, 0);
        chk({tag, ".err"},  error_o, 0);
    endtask

    // One PUT, judged at transaction level: the outcome comes from the rules
    // (ack within TO enabled lookup cycles? hit? free slot?), not from states.
    task automatic run_put(input string tag, input logic [KW-1:0] key, input logic [VW-1:0] val,
                           input logic hit, input logic [IW-1:0] lidx,
                           input logic fv, input logic [IW-1:0] fidx,
                           input int ack_d, input int en_pct);
        int lk = 0, nwr = 0, ndone = 0, nerr = 0, cyc = 0;
        bit fin = 0, started = 0;
        logic [IW-1:0] widx = '0;
        logic [KW-1:0] wkey = '0;
        logic [VW-1:0] wval = '0;
        bit acked, writes;
        logic [IW-1:0] exp_idx;
        acked   = (ack_d < TO);
        writes  = acked && (hit || fv);
        exp_idx = hit ? lidx : fidx;
        lookup_hit_i = hit; lookup_idx_i = lidx;
        free_valid_i = fv;  free_idx_i   = fidx;
        key_i = key; value_i = val;
        while (!fin && cyc < 400) begin
            en = ($urandom_range(99) < en_pct);
            if (started) begin
                key_i   = $urandom;
                value_i = {$urandom, $urandom};
            end
            if (lookup_req_o) lookup_ack_i = en && (lk == ack_d);
            else              lookup_ack_i = 1'($urandom_range(1));
            #1;
            if (!busy_o && en) started = 1;
            if (lookup_req_o && en) lk++;
            if (wr_en_o) begin
                nwr++;
                widx = wr_idx_o; wkey = wr_key_o; wval = wr_val_o;
            end
            if (done_o)  ndone++;
            if (error_o) nerr++;
            if (done_o || error_o) fin = 1;
            cyc++;
            next();
        end
        en = 0; lookup_ack_i = 0;
        #1;
        chk({tag, ".finished"}, fin, 1);
        chk({tag, ".busy_after"}, busy_o, 0);
        chk({tag, ".lookup_cycles"}, lk, acked ? ack_d + 1 : TO);
        chk({tag, ".wr_count"}, nwr, writes ? 1 : 0);
        chk({tag, ".done_count"}, ndone, writes ? 1 : 0);
        chk({tag, ".err_count"}, nerr, writes ? 0 : 1);
        if (writes) begin
            chk({tag, ".wr_idx"}, widx, exp_idx);
            chk({tag, ".wr_key"}, wkey, key);
            chk({tag, ".wr_val"}, wval, val);
        end
        next();
    endtask

    initial begin
        int nwr;
        rst = 1; en = 0; enter = 0; key_i = '0; value_i = '0;
        lookup_ack_i = 0; lookup_hit_i = 0; lookup_idx_i = '0;
        free_valid_i = 0; free_idx_i = '0;
        repeat (3) next();

        // Reset state
        chk_idle("reset");
        chk("reset.wr_idx", wr_idx_o, 0);
        chk("reset.wr_key", wr_key_o, 0);
        chk("reset.wr_val", wr_val_o, 0);
        chk("reset.lk_key", lookup_key_o, 0);
        rst = 0;
        next();

        // 1. Hit
        en = 1; key_i = 32'hA5; value_i = 64'h1111_2222_3333_4444;
        #1; chk("hit.c0.busy", busy_o, 0);
        next(); key_i = 32'hDEAD; value_i = '0;
        lookup_ack_i = 1; lookup_hit_i = 1; lookup_idx_i = 4'd3;
        #1; chk("hit.c1.req", lookup_req_o, 1); chk("hit.c1.key", lookup_key_o, 32'hA5);
        chk("hit.c1.wr", wr_en_o, 0);
        next(); lookup_ack_i = 0;
        #1; chk("hit.c2.wr", wr_en_o, 1); chk("hit.c2.idx", wr_idx_o, 3);
        chk("hit.c2.key", wr_key_o, 32'hA5); chk("hit.c2.val", wr_val_o, 64'h1111_2222_3333_4444);
        chk("hit.c2.req", lookup_req_o, 0);
        next();
        #1; chk("hit.c3.done", done_o, 1); chk("hit.c3.wr", wr_en_o, 0);
        next();
        #1; chk_idle("hit.c4");
        en = 0; next();

        // 2. Miss with allocation
        en = 1; key_i = 32'h1234_5678; value_i = 64'h55;
        next(); lookup_ack_i = 1; lookup_hit_i = 0; lookup_idx_i = 4'd9;
        free_valid_i = 1; free_idx_i = 4'd7;
        #1; chk("miss.c1.req", lookup_req_o, 1);
        next(); lookup_ack_i = 0;
        #1; chk("miss.c2.busy", busy_o, 1); chk("miss.c2.wr", wr_en_o, 0);
        chk("miss.c2.req", lookup_req_o, 0);
        next();
        #1; chk("miss.c3.wr", wr_en_o, 1); chk("miss.c3.idx", wr_idx_o, 7);
        chk("miss.c3.key", wr_key_o, 32'h1234_5678);
        next();
        #1; chk("miss.c4.done", done_o, 1);
        next();
        #1; chk_idle("miss.c5");
        en = 0; next();

        // 3. Cache full
        en = 1; key_i = 32'h77;
        next(); lookup_ack_i = 1; lookup_hit_i = 0; free_valid_i = 0;
        next(); lookup_ack_i = 0;
        #1; chk("full.c2.wr", wr_en_o, 0);
        next();
        #1; chk("full.c3.err", error_o, 1); chk("full.c3.wr", wr_en_o, 0);
        chk("full.c3.done", done_o, 0);
        next();
        #1; chk_idle("full.c4");
        en = 0; next();

        // 4. Lookup timeout
        en = 1; key_i = 32'h99; nwr = 0;
        for (int i = 0; i < TO; i++) begin
            next(); lookup_ack_i = 0;
            #1; chk("tmo.req", lookup_req_o, 1); chk("tmo.err_early", error_o, 0);
            nwr += int'(wr_en_o);
        end
        next();
        #1; chk("tmo.err", error_o, 1); chk("tmo.req_off", lookup_req_o, 0);
        nwr += int'(wr_en_o);
        next();
        #1; chk_idle("tmo.after"); chk("tmo.no_wr", nwr, 0);
        en = 0; next();

        // 5. Stall in WRITE
        en = 1; key_i = 32'hBEEF; value_i = 64'hCAFE;
        next(); lookup_ack_i = 1; lookup_hit_i = 1; lookup_idx_i = 4'd5;
        next(); lookup_ack_i = 0; en = 0; nwr = 0;
        for (int i = 0; i < 5; i++) begin
            #1; nwr += int'(wr_en_o); chk("stall.busy", busy_o, 1);
            next();
        end
        chk("stall.no_wr", nwr, 0);
        en = 1;
        #1; chk("stall.resume_wr", wr_en_o, 1); chk("stall.idx", wr_idx_o, 5);
        next();
        #1; chk("stall.wr_once", wr_en_o, 0); chk("stall.done", done_o, 1);
        next(); en = 0; next();

        // Repeated write to the same slot after a hit
        run_put("same_idx", 32'hBEEF, 64'hF00D, 1, 4'd5, 1, 4'd0, 0, 100);
        // Ack on the final timeout cycle wins
        run_put("ack_last", 32'h4242, 64'h1, 1, 4'd12, 0, 4'd0, TO - 1, 100);

        // enter during WRITE with en=1: no strobe
        en = 1; key_i = 32'h31;
        next(); lookup_ack_i = 1; lookup_hit_i = 1; lookup_idx_i = 4'd2;
        next(); lookup_ack_i = 0; enter = 1;
        #1; chk("enter_wr.wr", wr_en_o, 0);
        next(); enter = 0; en = 0;
        #1; chk_idle("enter_wr.after");
        next();

        // 6. Restart from LOOKUP, then reset together with enter
        en = 1; key_i = 32'h66;
        next(); lookup_ack_i = 0; enter = 1;
        #1; chk("restart.req_before", lookup_req_o, 1);
        next(); enter = 0; en = 0;
        #1; chk_idle("restart"); chk("restart.key_clr", lookup_key_o, 0);
        en = 1; key_i = 32'h88;
        next();
        next(); rst = 1; enter = 1;
        next(); rst = 0; enter = 0; en = 1;
        #1; chk_idle("rst_enter");
        chk("rst_enter.key", wr_key_o, 0); chk("rst_enter.idx", wr_idx_o, 0);
        en = 0; next();

        // Randomized PUTs with random en stalls and stray acks
        for (int t = 0; t < 40; t++) begin
            run_put($sformatf("rnd%0d", t), $urandom, {$urandom, $urandom},
                    1'($urandom_range(1)), 4'($urandom_range(15)),
                    ($urandom_range(3) != 0), 4'($urandom_range(15)),
                    $urandom_range(TO + 1), $urandom_range(40, 100));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
